// File: rtl/conway_pkg.sv
// Shared types for the conway board blocks.
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } reader_state_t;

endpackage

// File: rtl/dff.sv
// Write-enabled register with asynchronous active-high clear.
module dff #(
    parameter int SIZE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (we) q_d = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/board_reader.sv
// Snapshots the live board on start and streams it out row by row with valid/ready.
module board_reader
    import conway_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   board,
    output logic [WIDTH-1:0]          row_data,
    output logic [$clog2(HEIGHT)-1:0] row_idx,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic                      row_last,
    output logic                      busy,
    output logic                      done
);

    localparam int IW = $clog2(HEIGHT);
    localparam logic [IW-1:0] LAST_IDX = IW'(HEIGHT - 1);

    reader_state_t         state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  capture;
    logic                  xfer;
    logic [WIDTH*HEIGHT-1:0] snap;

    assign capture = (state_q == IDLE) && start;
    assign xfer    = valid_q && row_ready;

    dff #(.SIZE(WIDTH*HEIGHT)) u_snap (
        .clk   (clk),
        .reset (reset),
        .we    (capture),
        .d     (board),
        .q     (snap)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (LAST_IDX == '0);
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (xfer) begin
                    if (last_q) begin
                        // Index stays parked on the last row; it is only reset by the next capture.
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + IW'(1);
                        last_d = ((idx_q + IW'(1)) == LAST_IDX);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign row_data  = valid_q ? snap[int'(idx_q)*WIDTH +: WIDTH] : '0;
    assign row_idx   = idx_q;
    assign row_valid = valid_q;
    assign row_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_board_reader.sv
// Directed scoreboard bench for board_reader at WIDTH=4, HEIGHT=4.
module tb_board_reader;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        logic         last;
    } row_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [W*H-1:0]   board;
    logic [W-1:0]     row_data;
    logic [1:0]       row_idx;
    logic             row_valid;
    logic             row_ready;
    logic             row_last;
    logic             busy;
    logic             done;

    row_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_done = 1'b0;

    board_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .board     (board),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_last  (row_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the rows the DUT should stream for a board captured now.
    task automatic push_board(input logic [W*H-1:0] b);
        for (int r = 0; r < H; r++) begin
            row_t e;
            e.data = b[r*W +: W];
            e.idx  = r;
            e.last = (r == H - 1);
            sb.push_back(e);
        end
    endtask

    // Check one cycle at the negedge (inputs already applied), then advance one cycle.
    task automatic cyc();
        logic pend;
        pend = 1'b0;
        #1;
        chk("row_valid", 32'(row_valid), 32'(sb.size() > 0));
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'((sb.size() > 0) || exp_done));
        if (row_valid && sb.size() > 0) begin
            row_t e;
            e = sb[0];
            chk("row_data", 32'(row_data), 32'(e.data));
            chk("row_idx", 32'(row_idx), 32'(e.idx));
            chk("row_last", 32'(row_last), 32'(e.last));
            if (row_ready) begin
                void'(sb.pop_front());
                pend = e.last;
            end
        end else begin
            chk("row_data_idle", 32'(row_data), 32'(0));
        end
        exp_done = pend;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [W*H-1:0] b);
        board = b;
        start = 1'b1;
        cyc();
        start = 1'b0;
        push_board(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (sb.size() > 0 || exp_done); i++) cyc();
        cyc();
        chk("queue_empty", 32'(sb.size()), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(row_valid), 32'(0));
        chk({tag, "_last"}, 32'(row_last), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_idx"}, 32'(row_idx), 32'(0));
        chk({tag, "_data"}, 32'(row_data), 32'(0));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        board = '0;
        row_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Plain scan with ready held high.
        do_start(16'hA5C3);
        drain();

        // Consumer stalls for three cycles on row 1.
        do_start(16'hA5C3);
        cyc();
        row_ready = 1'b0;
        repeat (3) cyc();
        row_ready = 1'b1;
        drain();

        // Live board changes right after capture.
        do_start(16'hA5C3);
        board = 16'hFFFF;
        drain();

        // Start pulsed mid-scan must be ignored.
        do_start(16'hA5C3);
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        drain();

        // Reset mid-scan at row 2, then a fresh scan.
        do_start(16'hA5C3);
        cyc();
        cyc();
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        sb.delete();
        exp_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_start(16'h0001);
        drain();

        // Start held high: back-to-back scans.
        board = 16'h1234;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            push_board(board);
            repeat (H + 1) cyc();
        end
        start = 1'b0;
        cyc();
        chk("queue_empty_b2b", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/board_reader.md
BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, cells per row (>=1).
REQ-002 SHALL have parameter HEIGHT, default 8, rows per board (>=2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to snapshot the board and stream it out.
REQ-006 SHALL have port board  input  WIDTH*HEIGHT  live board; row r = board[r*WIDTH +: WIDTH].
REQ-007 SHALL have port row_data  output  WIDTH  snapshot row currently offered.
REQ-008 SHALL have port row_idx  output  $clog2(HEIGHT)  index of offered row.
REQ-009 SHALL have port row_valid  output  1  row_data/row_idx valid.
REQ-010 SHALL have port row_ready  input  1  consumer accepts row this cycle.
REQ-011 SHALL have port row_last  output  1  offered row is row HEIGHT-1.
REQ-012 SHALL have port busy  output  1  scan in progress (SCAN or DONE state).
REQ-013 SHALL have port done  output  1  one-cycle pulse after last row accepted.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 SHALL, in IDLE with start=1, capture board into an internal snapshot on that edge, set row index to 0, and enter SCAN.
REQ-016 SHALL ignore start while in SCAN or DONE (no re-capture, no index change).
REQ-017 SHALL drive row_valid=1 in every SCAN cycle and 0 in IDLE and DONE.
REQ-018 SHALL drive row_data = snapshot row row_idx, zero outside SCAN.
REQ-019 SHALL count a transfer only on a cycle with row_valid=1 and row_ready=1.
REQ-020 SHALL hold row_data, row_idx and row_last stable while row_valid=1 and row_ready=0.
REQ-021 SHALL increment row_idx by 1 on each non-last transfer; first row offered in the cycle after start is accepted.
REQ-022 SHALL assert row_last exactly when in SCAN and row_idx == HEIGHT-1.
REQ-023 SHALL, on transfer with row_last=1, enter DONE; row_idx never wraps within a scan.
REQ-024 SHALL assert done for exactly the one DONE cycle, then return to IDLE unconditionally.
REQ-025 SHALL make the stream independent of board changes after capture.
REQ-026 SHALL, with row_ready held high, deliver HEIGHT rows in HEIGHT consecutive cycles; start-to-done = HEIGHT+1 cycles.
REQ-027 SHALL drive busy=1 in SCAN and DONE, 0 in IDLE.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-scan, immediately enter IDLE and force row_valid, row_last, busy, done, row_idx and row_data to 0.
REQ-029 SHALL clear the snapshot register to 0 on reset.
REQ-030 SHALL accept a start on the first rising edge after reset deasserts.

Structure
REQ-031 SHALL take the FSM state enum (IDLE/SCAN/DONE) from the shared package conway_pkg.
REQ-032 SHALL instantiate the existing dff module (SIZE=WIDTH*HEIGHT, we = start accepted in IDLE) as the snapshot register.
REQ-033 SHALL keep the row counter and FSM inside board_reader with no further sub-modules.

Verification (WIDTH=4, HEIGHT=4)
REQ-034 SHALL cover: board=16'hA5C3, start pulse, row_ready=1 -> rows 3,C,5,A at idx 0..3 on consecutive cycles, row_last with A, done one cycle later.
REQ-035 SHALL cover: same board, row_ready low 3 cycles while idx=1 -> row_data=C, idx=1 held stable, then scan completes with 5,A.
REQ-036 SHALL cover: board changed to 16'hFFFF one cycle after start -> stream still 3,C,5,A.
REQ-037 SHALL cover: start pulsed again during SCAN at idx=2 -> ignored, sequence and done timing unchanged.
REQ-038 SHALL cover: reset asserted at idx=2 -> all outputs 0 immediately; new start with board=16'h0001 -> rows 1,0,0,0.
REQ-039 SHALL cover: start held high continuously -> back-to-back scans, each separated by exactly one DONE cycle and one IDLE capture cycle.
